// File: rtl/md_unit.sv
// ============================================================================
// Module   : md_unit
// Function : Iterative multiply/divide unit owning the HI/LO registers.
//            Optional macro MD_FAST_MULT_EN selects a single-cycle multiplier.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module md_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         md,
    input  logic [1:0]   alu_md,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op_mthi,
    input  logic         op_mtlo,
    input  logic         op_mfhi,
    input  logic         op_mflo,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         busy,
    output logic         stall
);

    localparam int c_CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(W - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_is_div;
    logic               r_res_neg;
    logic               r_rem_neg;
    logic               r_div0;
    logic [W-1:0]       r_a_orig;
    logic [W-1:0]       r_opb;
    logic [2*W-1:0]     r_acc;
    logic [W-1:0]       r_hi;
    logic [W-1:0]       r_lo;

    logic               w_idle;
    logic               w_signed;
    logic               w_start;
    logic [W-1:0]       w_abs_a;
    logic [W-1:0]       w_abs_b;
    logic [W:0]         w_mul_sum;
    logic [W:0]         w_div_trial;
    logic [W:0]         w_div_diff;
    logic               w_qbit;
    logic [W-1:0]       w_rem_nxt;
    logic [2*W-1:0]     w_prod;
    logic [W-1:0]       w_quo;
    logic [W-1:0]       w_rem;

    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_signed = ~alu_md[0];
    assign w_abs_a  = (w_signed && a[W-1]) ? -a : a;
    assign w_abs_b  = (w_signed && b[W-1]) ? -b : b;

`ifdef MD_FAST_MULT_EN
    logic [2*W-1:0] w_ext_a;
    logic [2*W-1:0] w_ext_b;
    logic [2*W-1:0] w_fast_prod;

    // Sign-extending to 2W bits makes the low 2W product bits correct for both signednesses
    assign w_ext_a     = {{W{w_signed & a[W-1]}}, a};
    assign w_ext_b     = {{W{w_signed & b[W-1]}}, b};
    assign w_fast_prod = w_ext_a * w_ext_b;
    assign w_start     = w_idle & md & alu_md[1];
`else
    assign w_start     = w_idle & md;
`endif

    // Multiply: acc = {partial product, remaining multiplier bits}, multiplicand in r_opb
    assign w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : {(W+1){1'b0}});

    // Divide: acc = {partial remainder, dividend/quotient bits}, divisor in r_opb
    assign w_div_trial = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_div_diff  = w_div_trial - {1'b0, r_opb};
    assign w_qbit      = ~w_div_diff[W];
    assign w_rem_nxt   = w_qbit ? w_div_diff[W-1:0] : w_div_trial[W-1:0];

    assign w_prod = r_res_neg ? -r_acc : r_acc;
    assign w_quo  = r_res_neg ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem  = r_rem_neg ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_start) w_state_nxt = c_ST_CALC;
            c_ST_CALC: if (r_cnt == c_CNT_LAST) w_state_nxt = c_ST_FIX;
            c_ST_FIX:  w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_res_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_div0    <= 1'b0;
            r_a_orig  <= '0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
`ifdef MD_FAST_MULT_EN
                    if (md && !alu_md[1]) begin
                        {r_hi, r_lo} <= w_fast_prod;
                    end else
`endif
                    if (md) begin
                        r_cnt     <= '0;
                        r_is_div  <= alu_md[1];
                        r_res_neg <= w_signed & (a[W-1] ^ b[W-1]);
                        r_rem_neg <= w_signed & a[W-1];
                        r_div0    <= (b == '0);
                        r_a_orig  <= a;
                        r_opb     <= alu_md[1] ? w_abs_b : w_abs_a;
                        r_acc     <= {{W{1'b0}}, (alu_md[1] ? w_abs_a : w_abs_b)};
                    end else begin
                        if (op_mthi) r_hi <= a;
                        if (op_mtlo) r_lo <= a;
                    end
                end
                c_ST_CALC: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    r_acc <= r_is_div ? {w_rem_nxt, r_acc[W-2:0], w_qbit}
                                      : {w_mul_sum, r_acc[W-1:1]};
                end
                c_ST_FIX: begin
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod;
                    end else if (r_div0) begin
                        r_hi <= r_a_orig;
                        r_lo <= {W{1'b1}};
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = ~w_idle;
    assign stall = busy & (md | op_mthi | op_mtlo | op_mfhi | op_mflo);

endmodule

`default_nettype wire
